// File: rtl/dac_window_sequencer_pkg.sv
// dac_window_sequencer_pkg: FSM state encoding and fsm_out status codes shared by the sequencer files.
package dac_window_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, STIM = 2'd2, REFRACT = 2'd3} state_t;
  localparam logic [7:0] OUT_IDLE    = 8'h40;
  localparam logic [7:0] OUT_TRACK   = 8'h20;
  localparam logic [7:0] OUT_STIM    = 8'h10;
  localparam logic [7:0] OUT_REFRACT = 8'h80;
  function automatic logic [7:0] status_code(state_t s);
    return s == IDLE ? OUT_IDLE : s == TRACK ? OUT_TRACK : s == STIM ? OUT_STIM : OUT_REFRACT;
  endfunction
endpackage

// File: rtl/dac_window_sequencer_cmp.sv
// dac_window_cmp: per-DAC window compare and qualification term (combinational).
//   count in, start_win/stop_win window bounds (inclusive), dac_en/thresh_out/edge_type per-DAC controls,
//   in_window out: count inside [start_win, stop_win]; qual out: DAC does not block advancing.
module dac_window_cmp #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] start_win,
  input  logic [CNT_W-1:0] stop_win,
  input  logic             dac_en,
  input  logic             thresh_out,
  input  logic             edge_type,
  output logic             in_window,
  output logic             qual
);
  assign in_window = (count >= start_win) && (count <= stop_win);
  assign qual      = ~dac_en | ~in_window | (thresh_out ^ edge_type);
endmodule

// File: rtl/dac_window_sequencer.sv
// dac_window_sequencer: qualifies DAC threshold outputs inside programmed windows and fires a stim trigger.
//   dataclk/reset_n clock and async active-low reset; sample_strobe paces state updates;
//   fsm_enable, dac_en, thresh_out, edge_type, start_win, stop_win, stop_max, refractory, stim_count_clr inputs;
//   window_count, in_window, fsm_state, fsm_out, stim_trigger, stim_count outputs.
module dac_window_sequencer
  import dac_window_sequencer_pkg::*;
#(
  parameter int N_DAC = 8,
  parameter int CNT_W = 16
) (
  input  logic                   dataclk,
  input  logic                   reset_n,
  input  logic                   sample_strobe,
  input  logic                   fsm_enable,
  input  logic [N_DAC-1:0]       dac_en,
  input  logic [N_DAC-1:0]       thresh_out,
  input  logic [N_DAC-1:0]       edge_type,
  input  logic [N_DAC*CNT_W-1:0] start_win,
  input  logic [N_DAC*CNT_W-1:0] stop_win,
  input  logic [CNT_W-1:0]       stop_max,
  input  logic [CNT_W-1:0]       refractory,
  input  logic                   stim_count_clr,
  output logic [CNT_W-1:0]       window_count,
  output logic [N_DAC-1:0]       in_window,
  output logic [1:0]             fsm_state,
  output logic [7:0]             fsm_out,
  output logic                   stim_trigger,
  output logic [15:0]            stim_count
);
  state_t             state, nxt_state;
  logic [CNT_W-1:0]   ref_cnt, nxt_ref, nxt_count;
  logic [N_DAC-1:0]   qual;
  logic               advance;
  for (genvar i = 0; i < N_DAC; i++) begin : g_cmp
    dac_window_cmp #(.CNT_W(CNT_W)) u_cmp (
      .count     (window_count),
      .start_win (start_win[i*CNT_W +: CNT_W]),
      .stop_win  (stop_win[i*CNT_W +: CNT_W]),
      .dac_en    (dac_en[i]),
      .thresh_out(thresh_out[i]),
      .edge_type (edge_type[i]),
      .in_window (in_window[i]),
      .qual      (qual[i])
    );
  end
  // With no DAC enabled every qual term is trivially 1, so require at least one participant.
  assign advance   = (&qual) && (|dac_en);
  assign fsm_state = state;
  always_comb begin
    nxt_state = state;
    nxt_count = window_count;
    nxt_ref   = ref_cnt;
    if (sample_strobe) begin
      case (state)
        IDLE: if (advance) begin
          nxt_state = stop_max == '0 ? STIM : TRACK;
          nxt_count = stop_max == '0 ? '0 : CNT_W'(1);
        end
        TRACK: begin
          nxt_state = !advance ? IDLE : window_count >= stop_max ? STIM : TRACK;
          nxt_count = (!advance || window_count >= stop_max) ? '0 : window_count + 1'b1;
        end
        STIM: begin
          nxt_state = refractory == '0 ? IDLE : REFRACT;
          nxt_ref   = refractory;
        end
        REFRACT: begin
          nxt_state = ref_cnt <= CNT_W'(1) ? IDLE : REFRACT;
          nxt_ref   = ref_cnt <= CNT_W'(1) ? '0 : ref_cnt - 1'b1;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      window_count <= '0;
      ref_cnt      <= '0;
      fsm_out      <= '0;
      stim_trigger <= 1'b0;
      stim_count   <= '0;
    end else begin
      state        <= fsm_enable ? nxt_state : IDLE;
      window_count <= fsm_enable ? nxt_count : '0;
      ref_cnt      <= fsm_enable ? nxt_ref : '0;
      fsm_out      <= fsm_enable ? status_code(nxt_state) : '0;
      stim_trigger <= fsm_enable && nxt_state == STIM && state != STIM;
      stim_count   <= stim_count_clr ? '0 :
                      (stim_trigger && stim_count != 16'hFFFF) ? stim_count + 1'b1 : stim_count;
    end
  end
endmodule

// File: tb/tb_dac_window_sequencer.sv
// tb_dac_window_sequencer: randomized scoreboard bench for dac_window_sequencer against a behavioural model.
module tb_dac_window_sequencer;
  localparam int N = 8;
  localparam int W = 16;
  logic             dataclk = 1'b0;
  logic             reset_n = 1'b0;
  logic             sample_strobe = 1'b0;
  logic             fsm_enable = 1'b0;
  logic             stim_count_clr = 1'b0;
  logic [N-1:0]     dac_en = '0;
  logic [N-1:0]     thresh_out = '0;
  logic [N-1:0]     edge_type = '0;
  logic [N*W-1:0]   start_win = '0;
  logic [N*W-1:0]   stop_win = '0;
  logic [W-1:0]     stop_max = '0;
  logic [W-1:0]     refractory = '0;
  logic [W-1:0]     window_count;
  logic [N-1:0]     in_window;
  logic [1:0]       fsm_state;
  logic [7:0]       fsm_out;
  logic             stim_trigger;
  logic [15:0]      stim_count;

  dac_window_sequencer #(.N_DAC(N), .CNT_W(W)) dut (
    .dataclk       (dataclk),
    .reset_n       (reset_n),
    .sample_strobe (sample_strobe),
    .fsm_enable    (fsm_enable),
    .dac_en        (dac_en),
    .thresh_out    (thresh_out),
    .edge_type     (edge_type),
    .start_win     (start_win),
    .stop_win      (stop_win),
    .stop_max      (stop_max),
    .refractory    (refractory),
    .stim_count_clr(stim_count_clr),
    .window_count  (window_count),
    .in_window     (in_window),
    .fsm_state     (fsm_state),
    .fsm_out       (fsm_out),
    .stim_trigger  (stim_trigger),
    .stim_count    (stim_count)
  );

  always #5 dataclk = ~dataclk;

  typedef struct {
    logic [1:0]   st;
    logic [W-1:0] cnt;
    logic [7:0]   out;
    logic         trig;
    logic [15:0]  sc;
    logic [N-1:0] inw;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int triggers_seen = 0;

  // Reference: sequence position, hold-off budget, pending trigger and stim tally as plain integers.
  int m_st = 0, m_cnt = 0, m_ref = 0, m_out = 0, m_trig = 0, m_sc = 0;
  int codes[4] = '{64, 32, 16, 128};

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit inside_win(int i, int c);
    return c >= int'(start_win[i*W +: W]) && c <= int'(stop_win[i*W +: W]);
  endfunction

  function automatic bit may_advance(int c);
    int n_en = 0;
    bit ok = 1;
    for (int i = 0; i < N; i++)
      if (dac_en[i]) begin
        n_en++;
        if (inside_win(i, c) && thresh_out[i] == edge_type[i]) ok = 0;
      end
    return ok && n_en > 0;
  endfunction

  task automatic model_edge();
    int ntrig = 0;
    if (!reset_n) begin
      m_st = 0; m_cnt = 0; m_ref = 0; m_out = 0; m_trig = 0; m_sc = 0;
      return;
    end
    if (stim_count_clr) m_sc = 0;
    else if (m_trig == 1 && m_sc < 65535) m_sc++;
    if (!fsm_enable) begin
      m_st = 0; m_cnt = 0; m_ref = 0; m_out = 0; m_trig = 0;
      return;
    end
    if (sample_strobe) begin
      bit adv = may_advance(m_cnt);
      if (m_st == 0) begin
        if (adv && stop_max == 0) begin m_st = 2; m_cnt = 0; ntrig = 1; end
        else if (adv) begin m_st = 1; m_cnt = 1; end
      end else if (m_st == 1) begin
        if (!adv) begin m_st = 0; m_cnt = 0; end
        else if (m_cnt >= int'(stop_max)) begin m_st = 2; m_cnt = 0; ntrig = 1; end
        else m_cnt++;
      end else if (m_st == 2) begin
        m_ref = int'(refractory);
        m_st = m_ref == 0 ? 0 : 3;
      end else begin
        m_ref--;
        if (m_ref <= 0) begin m_st = 0; m_ref = 0; end
      end
    end
    m_trig = ntrig;
    m_out = codes[m_st];
  endtask

  // Called at a falling edge with inputs already set; predicts the state after the coming rising edge.
  task automatic cyc(input bit stb);
    exp_t e;
    sample_strobe = stb;
    model_edge();
    e.st = 2'(m_st);
    e.cnt = W'(m_cnt);
    e.out = 8'(m_out);
    e.trig = m_trig[0];
    e.sc = 16'(m_sc);
    for (int i = 0; i < N; i++) e.inw[i] = inside_win(i, m_cnt);
    q.push_back(e);
    @(negedge dataclk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge dataclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fsm_state", fsm_state, e.st);
        chk("window_count", window_count, e.cnt);
        chk("fsm_out", fsm_out, e.out);
        chk("stim_trigger", stim_trigger, e.trig);
        chk("stim_count", stim_count, e.sc);
        chk("in_window", in_window, e.inw);
        if (stim_trigger) triggers_seen++;
      end
    end
  end

  task automatic configure();
    for (int i = 0; i < N; i++) begin
      start_win[i*W +: W] = W'($urandom_range(0, 6));
      stop_win[i*W +: W]  = W'($urandom_range(0, 12));
    end
    dac_en     = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
    stop_max   = W'($urandom_range(0, 5));
    refractory = W'($urandom_range(0, 3));
  endtask

  task automatic randomize_inputs();
    thresh_out = N'($urandom);
    for (int i = 0; i < N; i++)
      edge_type[i] = ~thresh_out[i] ^ ($urandom_range(0, 39) == 0);
    fsm_enable     = $urandom_range(0, 49) != 0;
    stim_count_clr = $urandom_range(0, 59) == 0;
  endtask

  task automatic qualify_all();
    thresh_out = '1;
    edge_type  = '0;
  endtask

  initial begin
    @(negedge dataclk);
    cyc(0);
    cyc(1);
    reset_n = 1'b1;
    fsm_enable = 1'b1;
    dac_en = 8'h01;
    stop_win[W-1:0] = 16'd20;
    stop_max = 16'd10;
    qualify_all();
    repeat (5) cyc(1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_count", window_count, 0);
    chk("async_reset_state", fsm_state, 0);
    chk("async_reset_fsm_out", fsm_out, 0);
    chk("async_reset_trigger", stim_trigger, 0);
    m_st = 0; m_cnt = 0; m_ref = 0; m_out = 0; m_trig = 0; m_sc = 0;
    @(negedge dataclk);
    cyc(1);
    reset_n = 1'b1;
    stop_win[W-1:0] = 16'd10;
    stop_max = 16'd3;
    refractory = 16'd2;
    repeat (8) cyc(1);
    for (int s = 0; s < 25; s++) begin
      configure();
      repeat (120) begin
        randomize_inputs();
        cyc($urandom_range(0, 2) == 0);
      end
    end
    force dut.stim_count = 16'hFFFD;
    #1 release dut.stim_count;
    m_sc = 65533;
    fsm_enable = 1'b1;
    stim_count_clr = 1'b0;
    dac_en = 8'hFF;
    stop_max = '0;
    refractory = '0;
    qualify_all();
    repeat (12) cyc(1);
    stim_count_clr = 1'b1;
    repeat (4) cyc(1);
    stim_count_clr = 1'b0;
    repeat (6) cyc(1);
    for (int s = 0; s < 10; s++) begin
      configure();
      repeat (100) begin
        randomize_inputs();
        cyc($urandom_range(0, 1) == 0);
      end
    end
    repeat (3) @(posedge dataclk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    total++;
    if (triggers_seen < 5) begin
      bad++;
      $display("FAIL trigger_coverage: got %0d expected at least 5", triggers_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
